falling_char_engine: RTL
========================

# falling_char_engine

Bookkeeping engine for the falling-character game: holds up to SLOTS live characters (ASCII, character column, pixel row, speed), accepts new characters from the random generator, advances them on each move tick, retires those that reach the bottom, and removes one on a keyboard hit. It sits between the character generator (upstream) and the VGA character renderer (downstream), which reads slot state through a registered read port.

## Interface
- SLOTS, 16: number of character slots (power of two, 2..64).
- Y_MAX, 464: first pixel row at which a character counts as missed (480 − 16-row glyph).
- clk  in  1  system clock (single domain).
- rst  in  1  reset, synchronous, active-high.
- move_tick  in  1  one-cycle pulse requesting one movement step.
- spawn_valid  in  1  generator offers a character.
- spawn_ready  out  1  engine accepts the offer this cycle.
- spawn_ascii  in  8  character code.
- spawn_col  in  7  character column 0..79.
- spawn_speed  in  4  pixels per move step.
- hit_valid  in  1  one-cycle pulse: key pressed.
- hit_ascii  in  8  ASCII of pressed key.
- hit_ack  out  1  one-cycle pulse: hit search finished.
- hit_found  out  1  valid with hit_ack: a slot was removed.
- rd_idx  in  log2(SLOTS)  slot queried by renderer.
- rd_valid / rd_ascii / rd_col / rd_y  out  1/8/7/9  state of queried slot.
- active_count  out  log2(SLOTS)+1  number of valid slots.
- score  out  8  successful hits, saturating at 255.
- miss_count  out  8  characters that reached Y_MAX, saturating at 255.

## Operation
- Per slot: valid, ascii[7:0], col[6:0], y[8:0], speed[3:0].
- States: IDLE, MOVE, HIT. FSM sweeps one slot per cycle in MOVE and HIT using index counter idx.
- move_pend set by move_tick in any state; cleared on entering MOVE. Extra ticks while pending coalesce (lost).
- hit_pend set with latched hit_ascii when hit_valid and hit_pend=0 and state≠HIT; hit_valid otherwise ignored.
- IDLE priority: move_pend → MOVE (idx=0); else hit_pend → HIT (idx=0); else spawn.
- spawn_ready = (state==IDLE) & !move_pend & !hit_pend & (active_count<SLOTS) & !rst. On spawn_valid&spawn_ready: lowest-index invalid slot written, y=0, valid=1.
- MOVE, slot idx valid: sum = y + speed in 10 bits; sum ≥ Y_MAX → valid=0, miss_count+1 (sat); else y=sum. Speed 0 never moves. After idx=SLOTS−1 → IDLE.
- HIT: first (lowest idx) valid slot with ascii==latched code is cleared, score+1 (sat), search stops. After match or idx=SLOTS−1 without match: hit_ack=1 next cycle with hit_found, hit_pend cleared, → IDLE.
- active_count updated same edge as any valid change.
- rd port: rd_* registered from slot rd_idx state before the edge; rd_idx≥SLOTS unreachable (width).

## Timing
- Reset: all slots invalid, y=0; state IDLE; move_pend=hit_pend=0; score, miss_count, active_count, rd_*, hit_ack, hit_found all 0; spawn_ready 0 while rst high, 1 in first cycle after (if spawn permitted).
- Reset mid-sweep aborts the sweep; no partial counter updates after reset edge.
- Spawn: accepted slot visible on rd port 2 cycles after accept edge (1 write + 1 read register).
- MOVE sweep: exactly SLOTS cycles; move_tick→sweep start 1 cycle from IDLE.
- HIT: latency from hit_valid to hit_ack ≤ SLOTS+2 cycles from IDLE; hit_ack high exactly 1 cycle.
- move_tick and hit_valid same cycle: both latched; MOVE runs first, then HIT.
- No spawn accepted during MOVE or HIT or while anything is pending.

## Test plan
- Reset, spawn 'A' col 5 speed 3; three move_ticks spaced ≥SLOTS+2 cycles → rd_idx=0 gives valid=1, ascii=0x41, col=5, y=9; active_count=1.
- Spawn speed 15 character, 31 ticks → y=465≥464 on 31st: slot cleared, miss_count=1, active_count=0.
- Fill 16 slots → spawn_ready=0 with spawn_valid held; 17th not accepted until a slot clears.
- Slots 2 and 7 hold 'K'; hit_valid 'K' → hit_ack with hit_found=1, slot 2 cleared, slot 7 intact, score=1; hit 'Z' → hit_found=0, score unchanged.
- move_tick and hit_valid same cycle → MOVE sweep completes, then hit_ack; second move_tick during sweep produces exactly one further sweep.
- Assert rst mid-MOVE → all rd_valid 0, counters 0, spawn_ready 1 cycle after rst falls.

Source files
------------

// File: rtl/falling_char_engine_if.sv
// Generator, keyboard-hit and renderer-read signals of the falling-character engine.
// The master side is the surrounding game logic; the engine uses the slave side.
interface falling_char_engine_if #(
    parameter int SLOTS = 16
);
    localparam int IW = $clog2(SLOTS);

    logic          move_tick;
    logic          spawn_valid;
    logic          spawn_ready;
    logic [7:0]    spawn_ascii;
    logic [6:0]    spawn_col;
    logic [3:0]    spawn_speed;
    logic          hit_valid;
    logic [7:0]    hit_ascii;
    logic          hit_ack;
    logic          hit_found;
    logic [IW-1:0] rd_idx;
    logic          rd_valid;
    logic [7:0]    rd_ascii;
    logic [6:0]    rd_col;
    logic [8:0]    rd_y;
    logic [IW:0]   active_count;
    logic [7:0]    score;
    logic [7:0]    miss_count;

    modport master (
        output move_tick, spawn_valid, spawn_ascii, spawn_col, spawn_speed,
               hit_valid, hit_ascii, rd_idx,
        input  spawn_ready, hit_ack, hit_found, rd_valid, rd_ascii, rd_col, rd_y,
               active_count, score, miss_count
    );

    modport slave (
        input  move_tick, spawn_valid, spawn_ascii, spawn_col, spawn_speed,
               hit_valid, hit_ascii, rd_idx,
        output spawn_ready, hit_ack, hit_found, rd_valid, rd_ascii, rd_col, rd_y,
               active_count, score, miss_count
    );
endinterface

// File: rtl/falling_char_engine.sv
// Slot bookkeeping for falling characters: spawn, per-tick movement sweep,
// keyboard-hit removal sweep, and a registered read port for the renderer.
//
// state | meaning
// IDLE  | accept spawns; dispatch pending move (first) or hit
// MOVE  | advance slot idx by its speed, retire at Y_MAX
// HIT   | search slot idx for the latched key code
module falling_char_engine #(
    parameter int SLOTS = 16,
    parameter int Y_MAX = 464
) (
    input logic                  clk,
    input logic                  rst,
    falling_char_engine_if.slave bus
);
    localparam int IW = $clog2(SLOTS);

    typedef enum logic [1:0] {IDLE, MOVE, HIT} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          move_pend;
    logic          hit_pend;
    logic [7:0]    hit_code;

    logic          slot_valid [SLOTS];
    logic [7:0]    slot_ascii [SLOTS];
    logic [6:0]    slot_col   [SLOTS];
    logic [8:0]    slot_y     [SLOTS];
    logic [3:0]    slot_speed [SLOTS];

    logic [IW:0]   active_count;
    logic [7:0]    score;
    logic [7:0]    miss_count;
    logic          hit_ack;
    logic          hit_found;
    logic          rd_valid;
    logic [7:0]    rd_ascii;
    logic [6:0]    rd_col;
    logic [8:0]    rd_y;

    logic          free_found;
    logic [IW-1:0] free_idx;
    logic [9:0]    move_sum;
    logic          hit_match;
    logic          last_slot;
    logic          spawn_ready;
    logic          spawn_fire;

    // Lowest-index free slot: scan downward so the smallest index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    assign move_sum    = {1'b0, slot_y[idx]} + {6'd0, slot_speed[idx]};
    assign hit_match   = slot_valid[idx] && (slot_ascii[idx] == hit_code);
    assign last_slot   = (idx == IW'(SLOTS - 1));
    assign spawn_ready = (state == IDLE) && !move_pend && !hit_pend
                         && (active_count < (IW + 1)'(SLOTS)) && !rst;
    assign spawn_fire  = spawn_ready && bus.spawn_valid && free_found;

    assign bus.spawn_ready  = spawn_ready;
    assign bus.hit_ack      = hit_ack;
    assign bus.hit_found    = hit_found;
    assign bus.rd_valid     = rd_valid;
    assign bus.rd_ascii     = rd_ascii;
    assign bus.rd_col       = rd_col;
    assign bus.rd_y         = rd_y;
    assign bus.active_count = active_count;
    assign bus.score        = score;
    assign bus.miss_count   = miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            move_pend    <= 1'b0;
            hit_pend     <= 1'b0;
            hit_code     <= '0;
            active_count <= '0;
            score        <= '0;
            miss_count   <= '0;
            hit_ack      <= 1'b0;
            hit_found    <= 1'b0;
            rd_valid     <= 1'b0;
            rd_ascii     <= '0;
            rd_col       <= '0;
            rd_y         <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_valid[i] <= 1'b0;
                slot_ascii[i] <= '0;
                slot_col[i]   <= '0;
                slot_y[i]     <= '0;
                slot_speed[i] <= '0;
            end
        end else begin
            hit_ack   <= 1'b0;
            hit_found <= 1'b0;

            rd_valid <= slot_valid[bus.rd_idx];
            rd_ascii <= slot_ascii[bus.rd_idx];
            rd_col   <= slot_col[bus.rd_idx];
            rd_y     <= slot_y[bus.rd_idx];

            if (bus.move_tick)
                move_pend <= 1'b1;
            if (bus.hit_valid && !hit_pend && state != HIT) begin
                hit_pend <= 1'b1;
                hit_code <= bus.hit_ascii;
            end

            case (state)
                IDLE: begin
                    // Clearing here overrides a tick in the same cycle: it coalesces.
                    if (move_pend) begin
                        state     <= MOVE;
                        idx       <= '0;
                        move_pend <= 1'b0;
                    end else if (hit_pend) begin
                        state <= HIT;
                        idx   <= '0;
                    end else if (spawn_fire) begin
                        slot_valid[free_idx] <= 1'b1;
                        slot_ascii[free_idx] <= bus.spawn_ascii;
                        slot_col[free_idx]   <= bus.spawn_col;
                        slot_y[free_idx]     <= '0;
                        slot_speed[free_idx] <= bus.spawn_speed;
                        active_count         <= active_count + 1'b1;
                    end
                end
                MOVE: begin
                    if (slot_valid[idx]) begin
                        if (move_sum >= 10'(Y_MAX)) begin
                            slot_valid[idx] <= 1'b0;
                            active_count    <= active_count - 1'b1;
                            miss_count      <= (miss_count == 8'hFF) ? miss_count : miss_count + 8'd1;
                        end else begin
                            slot_y[idx] <= move_sum[8:0];
                        end
                    end
                    idx <= idx + IW'(1);
                    if (last_slot)
                        state <= IDLE;
                end
                HIT: begin
                    if (hit_match || last_slot) begin
                        hit_ack   <= 1'b1;
                        hit_found <= hit_match;
                        hit_pend  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                    if (hit_match) begin
                        slot_valid[idx] <= 1'b0;
                        active_count    <= active_count - 1'b1;
                        score           <= (score == 8'hFF) ? score : score + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
